lcd_timing_gen: RTL and testbench

LCD_TIMING_GEN -- requirements
Module: lcd_timing_gen

---
 rtl/lcd_timing_pkg.sv | 33 +++
 rtl/lcd_delay_line.sv | 34 +++
 rtl/lcd_timing_gen.sv | 109 ++++++++++
 tb/tb_lcd_timing_gen.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/lcd_timing_pkg.sv
// Shared timing defaults, counter widths and sync polarity encoding for the LCD timing generator.
package lcd_timing_pkg;

  localparam int DEF_H_ACTIVE = 800;
  localparam int DEF_H_FP     = 210;
  localparam int DEF_H_SYNC   = 20;
  localparam int DEF_H_BP     = 26;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 22;
  localparam int DEF_V_SYNC   = 10;
  localparam int DEF_V_BP     = 13;
  localparam int DEF_PIPE_DLY = 3;

  localparam bit SYNC_ACTIVE_LOW  = 1'b0;
  localparam bit SYNC_ACTIVE_HIGH = 1'b1;

  localparam int H_CNT_W = 11;
  localparam int V_CNT_W = 10;
  localparam int X_W     = 10;
  localparam int Y_W     = 9;

  // Syncs are carried active-high internally; polarity is applied only at the pins.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic de;
  } sync_bus_t;

  function automatic logic apply_pol(logic raw, bit pol);
    return (pol == SYNC_ACTIVE_HIGH) ? raw : ~raw;
  endfunction

endpackage

// File: rtl/lcd_delay_line.sv
// Enable-gated shift register that delays the sync/DE bundle to match downstream pixel latency.
module lcd_delay_line #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  generate
    if (DEPTH == 0) begin : g_bypass
      logic unused_ctrl;
      assign unused_ctrl = ^{clk, rst_n, en_i};
      assign q_o = d_i;
    end else begin : g_shift
      logic [WIDTH-1:0] stage_q [DEPTH];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else if (en_i) begin
          stage_q[0] <= d_i;
          for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
      end

      assign q_o = stage_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/lcd_timing_gen.sv
// LCD panel timing generator: pixel/line counters, active-area coordinates, delayed syncs and DE.
module lcd_timing_gen
  import lcd_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_POL = SYNC_ACTIVE_LOW,
  parameter int PIPE_DLY = DEF_PIPE_DLY
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           pix_ce,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           hsync,
  output logic           vsync,
  output logic           de,
  output logic           frame_start,
  output logic           line_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [H_CNT_W-1:0] H_LAST     = H_CNT_W'(H_TOTAL - 1);
  localparam logic [H_CNT_W-1:0] H_ACT_END  = H_CNT_W'(H_ACTIVE);
  localparam logic [H_CNT_W-1:0] HS_START   = H_CNT_W'(H_ACTIVE + H_FP);
  localparam logic [H_CNT_W-1:0] HS_END     = H_CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [V_CNT_W-1:0] V_LAST     = V_CNT_W'(V_TOTAL - 1);
  localparam logic [V_CNT_W-1:0] V_ACT_END  = V_CNT_W'(V_ACTIVE);
  localparam logic [V_CNT_W-1:0] VS_START   = V_CNT_W'(V_ACTIVE + V_FP);
  localparam logic [V_CNT_W-1:0] VS_END     = V_CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  // The counters point at the pixel that the next enabled cycle presents on the outputs.
  logic [H_CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [V_CNT_W-1:0] v_cnt_q, v_cnt_d;
  logic [X_W-1:0]     x_q, x_d;
  logic [Y_W-1:0]     y_q, y_d;
  logic               frame_start_q, line_start_q;
  logic               h_wrap, v_wrap, h_act, v_act;
  sync_bus_t          raw_q, raw_d, dly;

  always_comb begin
    h_wrap  = (h_cnt_q == H_LAST);
    v_wrap  = (v_cnt_q == V_LAST);
    h_cnt_d = h_wrap ? '0 : h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (h_wrap) v_cnt_d = v_wrap ? '0 : v_cnt_q + 1'b1;

    h_act = (h_cnt_q < H_ACT_END);
    v_act = (v_cnt_q < V_ACT_END);
    x_d   = h_act ? h_cnt_q[X_W-1:0] : '0;
    y_d   = v_act ? v_cnt_q[Y_W-1:0] : '0;

    raw_d.hsync = (h_cnt_q >= HS_START) && (h_cnt_q < HS_END);
    raw_d.vsync = (v_cnt_q >= VS_START) && (v_cnt_q < VS_END);
    raw_d.de    = h_act && v_act;
  end

  // Pulses last a single clock even when pix_ce stays low afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      x_q           <= '0;
      y_q           <= '0;
      frame_start_q <= 1'b0;
      line_start_q  <= 1'b0;
      raw_q         <= '0;
    end else if (pix_ce) begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      x_q           <= x_d;
      y_q           <= y_d;
      frame_start_q <= (h_cnt_q == '0) && (v_cnt_q == '0);
      line_start_q  <= (h_cnt_q == '0);
      raw_q         <= raw_d;
    end else begin
      frame_start_q <= 1'b0;
      line_start_q  <= 1'b0;
    end
  end

  lcd_delay_line #(
    .WIDTH ($bits(sync_bus_t)),
    .DEPTH (PIPE_DLY)
  ) u_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (pix_ce),
    .d_i   (raw_q),
    .q_o   (dly)
  );

  assign x           = x_q;
  assign y           = y_q;
  assign frame_start = frame_start_q;
  assign line_start  = line_start_q;
  assign de          = dly.de;
  assign hsync       = apply_pol(dly.hsync, SYNC_POL);
  assign vsync       = apply_pol(dly.vsync, SYNC_POL);

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Scoreboard bench for lcd_timing_gen using a reduced 15x8 raster so full frames fit in a short run.
module tb_lcd_timing_gen;

  localparam int HA  = 8;
  localparam int HF  = 2;
  localparam int HS  = 3;
  localparam int HB  = 2;
  localparam int VA  = 4;
  localparam int VF  = 1;
  localparam int VS  = 2;
  localparam int VB  = 1;
  localparam int DLY = 3;
  localparam int HT  = HA + HF + HS + HB;
  localparam int VT  = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
    logic       hs;
    logic       vs;
    logic       de;
    logic       fs;
    logic       ls;
  } out_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pix_ce;
  logic [9:0] x;
  logic [8:0] y;
  logic       hsync, vsync, de, frame_start, line_start;

  int   total = 0;
  int   bad   = 0;
  int   nEn   = 0;
  out_t expQ[$];

  lcd_timing_gen #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .SYNC_POL (1'b0), .PIPE_DLY (DLY)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pix_ce      (pix_ce),
    .x           (x),
    .y           (y),
    .hsync       (hsync),
    .vsync       (vsync),
    .de          (de),
    .frame_start (frame_start),
    .line_start  (line_start)
  );

  always #5 clk = ~clk;

  // Expected outputs after nEnabled enabled edges since reset; ceLast tells whether the last edge was enabled.
  function automatic out_t expOut(int nEnabled, bit ceLast);
    out_t e;
    int p, h, v, q, hq, vq;
    e = '{x: 10'd0, y: 9'd0, hs: 1'b1, vs: 1'b1, de: 1'b0, fs: 1'b0, ls: 1'b0};
    if (nEnabled > 0) begin
      p = nEnabled - 1;
      h = p % HT;
      v = (p / HT) % VT;
      e.x  = (h < HA) ? 10'(h) : 10'd0;
      e.y  = (v < VA) ? 9'(v) : 9'd0;
      e.fs = ceLast && (h == 0) && (v == 0);
      e.ls = ceLast && (h == 0);
      if (p >= DLY) begin
        q  = p - DLY;
        hq = q % HT;
        vq = (q / HT) % VT;
        e.de = (hq < HA) && (vq < VA);
        e.hs = !((hq >= HA + HF) && (hq < HA + HF + HS));
        e.vs = !((vq >= VA + VF) && (vq < VA + VF + VS));
      end
    end
    return e;
  endfunction

  task automatic checkVal(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic checkOutput(input out_t e);
    out_t a;
    a = '{x: x, y: y, hs: hsync, vs: vsync, de: de, fs: frame_start, ls: line_start};
    total++;
    if (a !== e) begin
      bad++;
      $display("[TB] FAIL outputs @%0t: got x=%0d y=%0d hs=%b vs=%b de=%b fs=%b ls=%b expected x=%0d y=%0d hs=%b vs=%b de=%b fs=%b ls=%b",
               $time, a.x, a.y, a.hs, a.vs, a.de, a.fs, a.ls, e.x, e.y, e.hs, e.vs, e.de, e.fs, e.ls);
    end
  endtask

  task automatic applyStimulus(input bit ce);
    pix_ce = ce;
    @(posedge clk);
    #1;
    if (ce) nEn++;
    expQ.push_back(expOut(nEn, ce));
  endtask

  task automatic applyReset(input int cycles);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    nEn   = 0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
      expQ.push_back(expOut(0, 1'b0));
    end
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (expQ.size() > 0) checkOutput(expQ.pop_front());
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int deCnt, hsCnt, vsCnt, fsCnt, lsCnt;
    int fsA, fsB, guard;
    logic [15:0] pattern;

    rst_n  = 1'b0;
    pix_ce = 1'b1;
    deCnt = 0; hsCnt = 0; vsCnt = 0; fsCnt = 0; lsCnt = 0;
    applyReset(3);

    fsA = -1; fsB = -1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      applyStimulus(1'b1);
      if (frame_start) begin
        if (fsA < 0) fsA = i; else if (fsB < 0) fsB = i;
      end
      if (i >= FRAME) begin
        deCnt += int'(de);
        hsCnt += int'(!hsync);
        vsCnt += int'(!vsync);
        fsCnt += int'(frame_start);
        lsCnt += int'(line_start);
      end
    end
    checkVal("first frame_start index", fsA, 0);
    checkVal("frame period ce=1", fsB - fsA, FRAME);
    checkVal("de cycles per frame", deCnt, HA * VA);
    checkVal("hsync low cycles per frame", hsCnt, HS * VT);
    checkVal("vsync low cycles per frame", vsCnt, VS * HT);
    checkVal("frame_start per frame", fsCnt, 1);
    checkVal("line_start per frame", lsCnt, VT);

    fsA = -1; fsB = -1;
    for (int i = 0; i < 2 * FRAME + 10; i++) begin
      applyStimulus(i % 2 == 0);
      if (frame_start) begin
        if (fsA < 0) fsA = i; else if (fsB < 0) fsB = i;
      end
    end
    checkVal("toggle frame_start seen", int'(fsA >= 0 && fsB >= 0), 1);
    checkVal("frame period ce toggling", fsB - fsA, 2 * FRAME);

    pattern = 16'b1101_0011_1000_1110;
    for (int r = 0; r < 3; r++) begin
      for (int b = 0; b < 16; b++) applyStimulus(pattern[b]);
    end

    guard = 0;
    while ((nEn % FRAME) != (2 * HT + 5 + 1) && guard < 2 * FRAME) begin
      applyStimulus(1'b1);
      guard++;
    end
    checkVal("reached h=5 v=2", nEn % FRAME, 2 * HT + 5 + 1);
    applyReset(2);
    applyStimulus(1'b1);
    checkVal("restart frame_start", int'(frame_start), 1);
    checkVal("restart x", int'(x), 0);
    checkVal("restart y", int'(y), 0);
    for (int i = 0; i < FRAME + 10; i++) applyStimulus(1'b1);

    pix_ce = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkVal("scoreboard drained", expQ.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
